cm_loop_cnt: RTL and testbench

CM_LOOP_CNT -- requirements
Module: cm_loop_cnt

---
 rtl/cnna_pkg.sv | 16 +
 rtl/cm_loop_lvl.sv | 64 ++++++
 rtl/cm_loop_cnt.sv | 104 ++++++++++
 tb/tb_cm_loop_cnt.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnna_pkg.sv
// rtl/cnna_pkg.sv - shared defaults and FSM encoding for the nested loop counter

package cnna_pkg;

   // Default geometry: four nested levels of 8-bit counters.
   localparam int C_WIDTH_DEF  = 8;
   localparam int C_LEVELS_DEF = 4;

   // Sweep controller states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } cnt_state_t;

endpackage

// File: rtl/cm_loop_lvl.sv
// rtl/cm_loop_lvl.sv - one loop level: counter, latched upper, registered last-flag

module cm_loop_lvl
   import cnna_pkg::*;
#(
   parameter int C_WIDTH = C_WIDTH_DEF
) (
   input  logic               I_clk,
   input  logic               I_rst,
   input  logic               load,
   input  logic [C_WIDTH-1:0] upper_in,
   input  logic               inc,
   input  logic               wrap,
   output logic [C_WIDTH-1:0] cnt,
   output logic               last
);

   localparam logic [C_WIDTH-1:0] C_ONE = C_WIDTH'(1);

   logic [C_WIDTH-1:0] cnt_q;
   logic [C_WIDTH-1:0] cnt_d;
   logic [C_WIDTH-1:0] upper_q;
   logic [C_WIDTH-1:0] upper_d;
   logic               last_q;
   logic               last_d;

   // Next counter/upper value, and the last-flag derived from those next values
   // so the flag is already valid in the same cycle the counter shows its value.
   always_comb begin
      cnt_d   = cnt_q;
      upper_d = upper_q;
      if (load || I_rst) begin
         cnt_d   = '0;
         upper_d = upper_in;
      end else if (wrap) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = last_q ? '0 : cnt_q + C_ONE;
      end
      // An upper of 0 or 1 pins the level at 0 and makes it permanently last.
      if (upper_d <= C_ONE) begin
         last_d = 1'b1;
      end else begin
         last_d = (cnt_d == (upper_d - C_ONE));
      end
   end

   // Level state registers; reset takes the upper from the live input.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         cnt_q   <= '0;
         upper_q <= upper_in;
         last_q  <= last_d;
      end else begin
         cnt_q   <= cnt_d;
         upper_q <= upper_d;
         last_q  <= last_d;
      end
   end

   assign cnt  = cnt_q;
   assign last = last_q;

endmodule

// File: rtl/cm_loop_cnt.sv
// rtl/cm_loop_cnt.sv - nested multi-level loop counter with one-shot/free-run sweep control

module cm_loop_cnt
   import cnna_pkg::*;
#(
   parameter int C_WIDTH  = C_WIDTH_DEF,
   parameter int C_LEVELS = C_LEVELS_DEF
) (
   input  logic                         I_clk,
   input  logic                         I_rst,
   input  logic                         I_cnt_en,
   input  logic                         I_cnt_valid,
   input  logic                         I_one_shot,
   input  logic [C_LEVELS*C_WIDTH-1:0]  I_cnt_upper,
   output logic [C_LEVELS*C_WIDTH-1:0]  O_cnt,
   output logic [C_LEVELS-1:0]          O_over_flag,
   output logic                         O_busy,
   output logic                         O_done
);

   cnt_state_t          state_q;
   cnt_state_t          state_d;
   logic                busy_q;
   logic                done_q;
   logic                load;
   logic                advance;
   logic                terminal;
   logic [C_LEVELS-1:0] last_flag;
   logic [C_LEVELS-1:0] inc;

   // An enable drop wins over a coincident valid because advance needs I_cnt_en.
   assign load     = (state_q == ST_IDLE);
   assign advance  = (state_q == ST_RUN) && I_cnt_en && I_cnt_valid;
   assign terminal = advance && O_over_flag[C_LEVELS-1];

   genvar gi;
   generate
      for (gi = 0; gi < C_LEVELS; gi++) begin : g_lvl
         // Over-flag is a pure AND-prefix of registered last-flags.
         assign O_over_flag[gi] = &last_flag[gi:0];

         if (gi == 0) begin : g_inc0
            assign inc[gi] = advance;
         end else begin : g_incn
            assign inc[gi] = advance && O_over_flag[gi-1];
         end

         cm_loop_lvl #(
            .C_WIDTH (C_WIDTH)
         ) u_lvl (
            .I_clk    (I_clk),
            .I_rst    (I_rst),
            .load     (load),
            .upper_in (I_cnt_upper[gi*C_WIDTH +: C_WIDTH]),
            .inc      (inc[gi]),
            .wrap     (terminal),
            .cnt      (O_cnt[gi*C_WIDTH +: C_WIDTH]),
            .last     (last_flag[gi])
         );
      end
   endgenerate

   // Next-state logic for the sweep controller.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (I_cnt_en) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!I_cnt_en) begin
               state_d = ST_IDLE;
            end else if (terminal && I_one_shot) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!I_cnt_en) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register plus registered busy and done-pulse outputs.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == ST_RUN);
         done_q  <= terminal;
      end
   end

   assign O_busy = busy_q;
   assign O_done = done_q;

endmodule

// File: tb/tb_cm_loop_cnt.sv
// tb/tb_cm_loop_cnt.sv - directed self-checking bench for cm_loop_cnt

module tb_cm_loop_cnt;

   logic        I_clk;
   logic        I_rst;
   logic        I_cnt_en;
   logic        I_cnt_valid;
   logic        I_one_shot;
   logic [15:0] I_cnt_upper;
   logic [15:0] O_cnt;
   logic [1:0]  O_over_flag;
   logic        O_busy;
   logic        O_done;

   int total;
   int bad;

   cm_loop_cnt #(
      .C_WIDTH  (8),
      .C_LEVELS (2)
   ) dut (
      .I_clk       (I_clk),
      .I_rst       (I_rst),
      .I_cnt_en    (I_cnt_en),
      .I_cnt_valid (I_cnt_valid),
      .I_one_shot  (I_one_shot),
      .I_cnt_upper (I_cnt_upper),
      .O_cnt       (O_cnt),
      .O_over_flag (O_over_flag),
      .O_busy      (O_busy),
      .O_done      (O_done)
   );

   initial I_clk = 1'b0;
   always #5 I_clk = ~I_clk;

   task automatic step();
      @(posedge I_clk);
      #1;
   endtask

   // Reset, idle one cycle, then enable; returns with the DUT in RUN at count 0.
   task automatic start(input logic [7:0] u1, input logic [7:0] u0, input logic os);
      I_rst       = 1'b1;
      I_cnt_en    = 1'b0;
      I_cnt_valid = 1'b0;
      I_one_shot  = os;
      I_cnt_upper = {u1, u0};
      step();
      I_rst = 1'b0;
      step();
      I_cnt_en = 1'b1;
      step();
   endtask

   task automatic test_reset();
      I_rst       = 1'b1;
      I_cnt_en    = 1'b1;
      I_cnt_valid = 1'b1;
      I_one_shot  = 1'b0;
      I_cnt_upper = {8'd4, 8'd1};
      step();
      step();
      total++; if (O_cnt !== 16'h0000) begin bad++; $display("FAIL reset_cnt got=%h want=%h", O_cnt, 16'h0000); end
      total++; if (O_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", O_busy); end
      total++; if (O_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", O_done); end
      total++; if (O_over_flag !== 2'b01) begin bad++; $display("FAIL reset_over got=%b want=01", O_over_flag); end
      I_rst = 1'b0;
      I_cnt_en = 1'b0;
      I_cnt_valid = 1'b0;
      step();
   endtask

   task automatic test_one_shot();
      logic [7:0] e0 [5] = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
      logic [7:0] e1 [5] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2};
      start(8'd3, 8'd2, 1'b1);
      total++; if (O_busy !== 1'b1) begin bad++; $display("FAIL os_busy_start got=%b want=1", O_busy); end
      total++; if (O_cnt !== 16'h0000) begin bad++; $display("FAIL os_cnt_start got=%h want=0000", O_cnt); end
      I_cnt_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         total++; if (O_cnt !== {e1[k], e0[k]}) begin bad++; $display("FAIL os_seq%0d got=%h want=%h", k, O_cnt, {e1[k], e0[k]}); end
         total++; if (O_done !== 1'b0) begin bad++; $display("FAIL os_nodone%0d got=%b want=0", k, O_done); end
      end
      total++; if (O_over_flag !== 2'b11) begin bad++; $display("FAIL os_over got=%b want=11", O_over_flag); end
      step();
      total++; if (O_cnt !== 16'h0000) begin bad++; $display("FAIL os_wrap got=%h want=0000", O_cnt); end
      total++; if (O_done !== 1'b1) begin bad++; $display("FAIL os_done got=%b want=1", O_done); end
      total++; if (O_busy !== 1'b0) begin bad++; $display("FAIL os_busy_done got=%b want=0", O_busy); end
      step();
      total++; if (O_done !== 1'b0) begin bad++; $display("FAIL os_done_once got=%b want=0", O_done); end
      total++; if (O_cnt !== 16'h0000) begin bad++; $display("FAIL os_hold got=%h want=0000", O_cnt); end
      total++; if (O_busy !== 1'b0) begin bad++; $display("FAIL os_busy_stay got=%b want=0", O_busy); end
      I_cnt_en = 1'b0;
      I_cnt_valid = 1'b0;
      step();
   endtask

   task automatic test_free_run();
      int npulse;
      npulse = 0;
      start(8'd3, 8'd2, 1'b0);
      I_cnt_valid = 1'b1;
      for (int v = 1; v <= 13; v++) begin
         step();
         if (O_done === 1'b1) npulse++;
         total++; if (O_done !== ((v == 6) || (v == 12))) begin bad++; $display("FAIL fr_done_v%0d got=%b want=%b", v, O_done, ((v == 6) || (v == 12))); end
      end
      I_cnt_valid = 1'b0;
      total++; if (O_cnt !== {8'd0, 8'd1}) begin bad++; $display("FAIL fr_final got=%h want=%h", O_cnt, {8'd0, 8'd1}); end
      total++; if (O_busy !== 1'b1) begin bad++; $display("FAIL fr_busy got=%b want=1", O_busy); end
      total++; if (npulse !== 2) begin bad++; $display("FAIL fr_pulses got=%0d want=2", npulse); end
      I_cnt_en = 1'b0;
      step();
   endtask

   task automatic test_upper_one();
      logic [7:0] e1;
      start(8'd4, 8'd1, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         e1 = 8'(k % 4);
         I_cnt_valid = 1'b1;
         step();
         total++; if (O_cnt !== {e1, 8'd0}) begin bad++; $display("FAIL u1_cnt%0d got=%h want=%h", k, O_cnt, {e1, 8'd0}); end
         total++; if (O_over_flag[0] !== 1'b1) begin bad++; $display("FAIL u1_over0_%0d got=%b want=1", k, O_over_flag[0]); end
         total++; if (O_done !== (e1 == 8'd0)) begin bad++; $display("FAIL u1_done%0d got=%b want=%b", k, O_done, (e1 == 8'd0)); end
         I_cnt_valid = 1'b0;
         step();
         total++; if (O_cnt !== {e1, 8'd0}) begin bad++; $display("FAIL u1_hold%0d got=%h want=%h", k, O_cnt, {e1, 8'd0}); end
      end
      I_cnt_en = 1'b0;
      step();
   endtask

   task automatic test_rst_mid();
      start(8'd3, 8'd3, 1'b0);
      I_cnt_valid = 1'b1;
      repeat (5) step();
      total++; if (O_cnt !== {8'd1, 8'd2}) begin bad++; $display("FAIL rm_pre got=%h want=%h", O_cnt, {8'd1, 8'd2}); end
      I_rst = 1'b1;
      step();
      total++; if (O_cnt !== 16'h0000) begin bad++; $display("FAIL rm_cnt got=%h want=0000", O_cnt); end
      total++; if (O_busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b want=0", O_busy); end
      total++; if (O_done !== 1'b0) begin bad++; $display("FAIL rm_done got=%b want=0", O_done); end
      I_rst = 1'b0;
      step();
      total++; if (O_cnt !== 16'h0000) begin bad++; $display("FAIL rm_idle_cnt got=%h want=0000", O_cnt); end
      total++; if (O_busy !== 1'b1) begin bad++; $display("FAIL rm_idle_busy got=%b want=1", O_busy); end
      step();
      total++; if (O_cnt !== {8'd0, 8'd1}) begin bad++; $display("FAIL rm_resume got=%h want=%h", O_cnt, {8'd0, 8'd1}); end
      I_cnt_en = 1'b0;
      I_cnt_valid = 1'b0;
      step();
   endtask

   task automatic test_en_drop();
      start(8'd3, 8'd2, 1'b0);
      I_cnt_valid = 1'b1;
      repeat (5) step();
      total++; if (O_over_flag !== 2'b11) begin bad++; $display("FAIL ed_over got=%b want=11", O_over_flag); end
      I_cnt_en = 1'b0;
      step();
      total++; if (O_done !== 1'b0) begin bad++; $display("FAIL ed_done got=%b want=0", O_done); end
      total++; if (O_busy !== 1'b0) begin bad++; $display("FAIL ed_busy got=%b want=0", O_busy); end
      step();
      total++; if (O_cnt !== 16'h0000) begin bad++; $display("FAIL ed_cnt got=%h want=0000", O_cnt); end
      total++; if (O_done !== 1'b0) begin bad++; $display("FAIL ed_done2 got=%b want=0", O_done); end
      I_cnt_valid = 1'b0;
      step();
   endtask

   task automatic test_upper_change();
      start(8'd1, 8'd3, 1'b0);
      I_cnt_upper = {8'd1, 8'd5};
      I_cnt_valid = 1'b1;
      step();
      total++; if (O_cnt[7:0] !== 8'd1) begin bad++; $display("FAIL uc_c1 got=%0d want=1", O_cnt[7:0]); end
      step();
      total++; if (O_cnt[7:0] !== 8'd2) begin bad++; $display("FAIL uc_c2 got=%0d want=2", O_cnt[7:0]); end
      step();
      total++; if (O_cnt[7:0] !== 8'd0) begin bad++; $display("FAIL uc_wrap got=%0d want=0", O_cnt[7:0]); end
      total++; if (O_done !== 1'b1) begin bad++; $display("FAIL uc_done got=%b want=1", O_done); end
      I_cnt_valid = 1'b0;
      I_cnt_en = 1'b0;
      step();
   endtask

   task automatic test_max_upper();
      start(8'd1, 8'd255, 1'b0);
      I_cnt_valid = 1'b1;
      repeat (254) step();
      total++; if (O_cnt[7:0] !== 8'd254) begin bad++; $display("FAIL mx_top got=%0d want=254", O_cnt[7:0]); end
      total++; if (O_over_flag !== 2'b11) begin bad++; $display("FAIL mx_over got=%b want=11", O_over_flag); end
      total++; if (O_done !== 1'b0) begin bad++; $display("FAIL mx_nodone got=%b want=0", O_done); end
      step();
      total++; if (O_cnt[7:0] !== 8'd0) begin bad++; $display("FAIL mx_wrap got=%0d want=0", O_cnt[7:0]); end
      total++; if (O_done !== 1'b1) begin bad++; $display("FAIL mx_done got=%b want=1", O_done); end
      I_cnt_valid = 1'b0;
      I_cnt_en = 1'b0;
      step();
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      I_rst       = 1'b1;
      I_cnt_en    = 1'b0;
      I_cnt_valid = 1'b0;
      I_one_shot  = 1'b0;
      I_cnt_upper = '0;
      test_reset();
      test_one_shot();
      test_free_run();
      test_upper_one();
      test_rst_mid();
      test_en_drop();
      test_upper_change();
      test_max_upper();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
